it_sequencer: RTL and testbench

//  Controller in front of the IT core. Buffers operand bytes from a host (valid/ready) and presents them one at a

---
 rtl/it_seq_pkg.sv | 21 ++
 rtl/it_seq_fifo.sv | 74 +++++++
 rtl/it_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_it_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/it_seq_pkg.sv
// it_seq_pkg: shared definitions for the IT sequencer.
//  - seq_state_t : sequencer FSM states (IDLE, ENTER, WAIT_HALT, CAPTURE)
//  - DATA_W_DEFAULT : default operand/result width, matches the IT core bus
//  - ptr_width() : pointer width for a power-of-two FIFO depth
package it_seq_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ENTER     = 2'd1,
    WAIT_HALT = 2'd2,
    CAPTURE   = 2'd3
  } seq_state_t;

  // Depth 1 would give a zero-width pointer; clamp to one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/it_seq_fifo.sv
// it_seq_fifo: operand buffer with a registered read port.
//  dout is loaded on a pop and holds until the next pop, so a word pushed into an
//  empty FIFO can be popped the following cycle and appears on dout after that pop.
//  A push while full is refused even when a pop happens in the same cycle.
// Ports:
//  clk, rst      clock, asynchronous active-high reset
//  push, din     write request and data (ignored when full)
//  pop           read request (ignored when empty)
//  dout          last popped word (0 after reset)
//  full, empty   occupancy flags
module it_seq_fifo
  import it_seq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic [DATA_W-1:0] dout_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = dout_reg;

  // Storage array kept free of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        dout_reg   <= mem[rd_ptr_reg];
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/it_sequencer.sv
// it_sequencer: controller in front of the IT core.
//  Buffers host operands, presents each on Input with an Enter strobe, waits for a
//  fresh Halt rising edge, captures Output into a result register for the host.
// Ports:
//  Clock, Reset          clock, asynchronous active-high reset
//  InValid/InData/InReady  host operand stream (InReady = FIFO not full)
//  Enter, Input          strobe and operand towards the IT core
//  Halt, Output          completion level and result from the IT core
//  ResValid/ResData/ResReady  result stream to the host
//  Busy                  high whenever the FSM is not IDLE
//  Timeout               sticky abort flag
// Build option: define IT_SEQ_TIMEOUT_EN to abort WAIT_HALT after TIMEOUT_CYCLES
//  cycles; otherwise WAIT_HALT waits indefinitely and Timeout is constant 0.
module it_sequencer
  import it_seq_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH     = 4,
  parameter int ENTER_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InValid,
  input  logic [DATA_W-1:0] InData,
  output logic              InReady,
  output logic              Enter,
  output logic [DATA_W-1:0] Input,
  input  logic              Halt,
  input  logic [DATA_W-1:0] Output,
  output logic              ResValid,
  output logic [DATA_W-1:0] ResData,
  input  logic              ResReady,
  output logic              Busy,
  output logic              Timeout
);

  localparam logic [1:0] S_IDLE      = IDLE;
  localparam logic [1:0] S_ENTER     = ENTER;
  localparam logic [1:0] S_WAIT_HALT = WAIT_HALT;
  localparam logic [1:0] S_CAPTURE   = CAPTURE;

  localparam int ENTER_W = $clog2(ENTER_CYCLES + 1);
  localparam logic [ENTER_W-1:0] ENTER_LOAD = ENTER_W'(ENTER_CYCLES - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("it_sequencer: FIFO_DEPTH must be a power of two >= 2");
  end
  if (ENTER_CYCLES < 1) begin : g_bad_enter
    $error("it_sequencer: ENTER_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("it_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  logic [1:0]         state_reg;
  logic [ENTER_W-1:0] enter_cnt_reg;
  logic               armed_reg;
  logic               res_valid_reg;
  logic [DATA_W-1:0]  res_data_reg;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [DATA_W-1:0]  fifo_dout;
  logic               capture_hit;
  logic               timeout_hit;
  logic               res_free;

  // The FIFO's registered read port doubles as the Input register: it only
  // changes on a pop, and pops happen only in IDLE, so Input is stable from
  // ENTER through CAPTURE.
  it_seq_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (InValid),
    .pop   (fifo_pop),
    .din   (InData),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_pop    = (state_reg == S_IDLE) && !fifo_empty;
  assign InReady     = !fifo_full;
  assign Input       = fifo_dout;
  assign Enter       = (state_reg == S_ENTER);
  assign Busy        = (state_reg != S_IDLE);
  assign ResValid    = res_valid_reg;
  assign ResData     = res_data_reg;
  // Only a Halt seen high after it was seen low counts; a level left over from
  // the previous operation must not complete this one.
  assign capture_hit = (state_reg == S_WAIT_HALT) && armed_reg && Halt;
  assign res_free    = !res_valid_reg || ResReady;

`ifdef IT_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_cnt_reg;
  logic            timeout_reg;

  assign timeout_hit = (state_reg == S_WAIT_HALT) && !capture_hit &&
                       (wait_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
  assign Timeout     = timeout_reg;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      if (state_reg == S_WAIT_HALT) begin
        wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
      end else begin
        wait_cnt_reg <= '0;
      end
      if (timeout_hit) begin
        timeout_reg <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign Timeout     = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg     <= S_IDLE;
      enter_cnt_reg <= '0;
      armed_reg     <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      // Host take; a reload in CAPTURE below overrides this in the same cycle.
      if (res_valid_reg && ResReady) begin
        res_valid_reg <= 1'b0;
      end
      case (state_reg)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_reg     <= S_ENTER;
            enter_cnt_reg <= ENTER_LOAD;
            armed_reg     <= 1'b0;
          end
        end
        S_ENTER: begin
          if (!Halt) begin
            armed_reg <= 1'b1;
          end
          if (enter_cnt_reg == '0) begin
            state_reg <= S_WAIT_HALT;
          end else begin
            enter_cnt_reg <= enter_cnt_reg - ENTER_W'(1);
          end
        end
        S_WAIT_HALT: begin
          if (capture_hit) begin
            state_reg <= S_CAPTURE;
          end else begin
            if (!Halt) begin
              armed_reg <= 1'b1;
            end
            if (timeout_hit) begin
              state_reg <= S_IDLE;
            end
          end
        end
        default: begin // S_CAPTURE
          if (res_free) begin
            res_data_reg  <= Output;
            res_valid_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_it_sequencer.sv
// tb_it_sequencer: directed bench for it_sequencer with a result scoreboard and an
// Enter/Input scoreboard. Expected results and operands are queued by the stimulus;
// monitors pop and compare when the DUT presents them. Define IT_SEQ_TIMEOUT_EN to
// include the timeout scenario.
module tb_it_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       enter;
  logic [7:0] core_in;
  logic       halt;
  logic [7:0] core_out;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready;
  logic       busy;
  logic       timeout;

  it_sequencer #(
    .DATA_W         (8),
    .FIFO_DEPTH     (4),
    .ENTER_CYCLES   (1),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .Clock    (clk),
    .Reset    (rst),
    .InValid  (in_valid),
    .InData   (in_data),
    .InReady  (in_ready),
    .Enter    (enter),
    .Input    (core_in),
    .Halt     (halt),
    .Output   (core_out),
    .ResValid (res_valid),
    .ResData  (res_data),
    .ResReady (res_ready),
    .Busy     (busy),
    .Timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q[$];      // expected results, in order
  logic [7:0] exp_in_q[$];   // expected operands at each Enter, in order
  logic [7:0] model_vals[$]; // values the core model will produce
  logic       model_on;
  int         model_delay;

  logic       enter_prev;
  int         enter_width;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL push_timeout: InReady stayed 0 for %0d cycles, required 1", n);
    end
    tick();
    in_valid = 1'b0;
    $display("push %h", b);
  endtask

  task automatic wait_res(input string name);
    int n;
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    check({name, "_resvalid"}, res_valid, 1);
  endtask

  // Core model: on Enter, drop Halt, then raise it with the next value after model_delay cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_on && enter && !rst) begin
        halt = 1'b0;
        repeat (model_delay) @(posedge clk);
        #1;
        if (model_vals.size() > 0) core_out = model_vals.pop_front();
        halt = 1'b1;
      end
    end
  end

  // Result monitor: a transfer happens at the next edge when valid && ready.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL result_unexpected: got %h, no result expected", res_data);
        end else begin
          e = exp_q.pop_front();
          check("result_data", res_data, e);
          $display("result %h expected %h", res_data, e);
        end
      end
    end
  end

  // Operand monitor: checks Input at each Enter rise and the strobe width.
  initial begin
    enter_prev  = 1'b0;
    enter_width = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        enter_prev  = 1'b0;
        enter_width = 0;
      end else begin
        if (enter) begin
          if (!enter_prev) begin
            if (exp_in_q.size() == 0) begin
              total++;
              $display("FAIL enter_unexpected: Enter with Input=%h, none expected", core_in);
            end else begin
              check("enter_input", core_in, exp_in_q.pop_front());
              $display("enter input %h", core_in);
            end
          end
          enter_width++;
        end else if (enter_prev) begin
          check("enter_width", enter_width, 1);
          enter_width = 0;
        end
        enter_prev = enter;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
    halt = 1'b0; core_out = '0; model_on = 1'b0; model_delay = 5;
    repeat (2) tick();
    check("rst_inready", in_ready, 1);
    check("rst_enter", enter, 0);
    check("rst_input", core_in, 0);
    check("rst_resvalid", res_valid, 0);
    check("rst_resdata", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    tick();

    // 1: single operation
    model_vals.push_back(8'hA5); exp_q.push_back(8'hA5); exp_in_q.push_back(8'h3C);
    model_delay = 5; model_on = 1'b1;
    push(8'h3C);
    check("t1_enter_not_yet", enter, 0);
    tick();
    check("t1_enter", enter, 1);
    check("t1_input", core_in, 8'h3C);
    check("t1_busy", busy, 1);
    tick();
    check("t1_enter_drop", enter, 0);
    wait_res("t1");
    check("t1_resdata", res_data, 8'hA5);
    check("t1_busy_after", busy, 0);
    tick();
    check("t1_resvalid_clear", res_valid, 0);

    // 2: fill the buffer while the core is stalled
    model_on = 1'b0; halt = 1'b0;
    exp_in_q.push_back(8'h10);
    push(8'h10);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      exp_in_q.push_back(8'h11 * (i + 1));
      push(8'h11 * (i + 1));
    end
    check("t2_full", in_ready, 0);
    in_valid = 1'b1; in_data = 8'h55;
    exp_in_q.push_back(8'h55);
    repeat (3) begin
      tick();
      check("t2_held", in_ready, 0);
    end
    for (int i = 0; i < 5; i++) begin
      model_vals.push_back(8'hA1 + 8'(i));
    end
    exp_q.push_back(8'h90);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'hA1 + 8'(i));
    model_delay = 2; model_on = 1'b1;
    core_out = 8'h90; halt = 1'b1;
    tick(); tick();
    check("t2_still_full", in_ready, 0);
    tick();
    check("t2_room_after_pop", in_ready, 1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while ((busy || exp_q.size() > 0) && n < 300) begin tick(); n++; end
    check("t2_drain", exp_q.size(), 0);

    // 3: result backpressure
    model_delay = 3; res_ready = 1'b0;
    model_vals.push_back(8'hB1); model_vals.push_back(8'hB2);
    exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
    exp_in_q.push_back(8'hC1); exp_in_q.push_back(8'hC2);
    push(8'hC1);
    push(8'hC2);
    repeat (30) tick();
    check("t3_resvalid", res_valid, 1);
    check("t3_resdata_first", res_data, 8'hB1);
    check("t3_busy_stall", busy, 1);
    check("t3_input_stall", core_in, 8'hC2);
    repeat (3) tick();
    check("t3_input_stable", core_in, 8'hC2);
    check("t3_busy_stable", busy, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t3_resvalid_reload", res_valid, 1);
    check("t3_resdata_second", res_data, 8'hB2);
    check("t3_busy_done", busy, 0);
    res_ready = 1'b1;
    tick(); tick();
    check("t3_resvalid_clear", res_valid, 0);

    // 4: stale halt
    model_on = 1'b0; core_out = 8'hEE; halt = 1'b1;
    exp_in_q.push_back(8'h4D);
    push(8'h4D);
    repeat (8) tick();
    check("t4_no_capture", res_valid, 0);
    check("t4_busy", busy, 1);
    halt = 1'b0;
    tick(); tick();
    core_out = 8'h5A; halt = 1'b1;
    exp_q.push_back(8'h5A);
    wait_res("t4");
    check("t4_resdata", res_data, 8'h5A);
    tick();

    // 5: reset in WAIT_HALT with two operands buffered
    halt = 1'b0;
    exp_in_q.push_back(8'h61);
    push(8'h61); push(8'h62); push(8'h63);
    repeat (4) tick();
    check("t5_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("t5_inready", in_ready, 1);
    check("t5_enter", enter, 0);
    check("t5_input", core_in, 0);
    check("t5_resvalid", res_valid, 0);
    check("t5_resdata", res_data, 0);
    check("t5_busy", busy, 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("t5_after_resvalid", res_valid, 0);
    check("t5_after_busy", busy, 0);
    check("t5_after_inready", in_ready, 1);

`ifdef IT_SEQ_TIMEOUT_EN
    // 6: timeout
    halt = 1'b0;
    exp_in_q.push_back(8'h71); exp_in_q.push_back(8'h72);
    push(8'h71);
    push(8'h72);
    check("t6_enter_first", enter, 1);
    repeat (10) tick();
    check("t6_timeout_early", timeout, 0);
    tick();
    check("t6_timeout", timeout, 1);
    check("t6_resvalid", res_valid, 0);
    tick();
    check("t6_next_enter", enter, 1);
    check("t6_next_input", core_in, 8'h72);
    repeat (15) tick();
    check("t6_idle", busy, 0);
    check("t6_sticky", timeout, 1);
`endif

    repeat (3) tick();
    check("end_results_pending", exp_q.size(), 0);
    check("end_operands_pending", exp_in_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
